plic_target_ctrl: RTL

- Per-target claim/complete sequencer for the PLIC.
- Owns the pending and in-service state for every source. It feeds pending bits into the priority-resolution chain and reads back the chain's winning priority/ID.
- Drives the target notification and serves claim reads and complete writes from the register interface.
- Releases each source's gateway only after that source completes.

---
 rtl/plic_target_ctrl_pkg.sv | 19 +
 rtl/plic_source_state.sv | 50 +++++
 rtl/plic_target_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/plic_target_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plic_target_ctrl_pkg
// Description : Shared constants and FSM encoding for the PLIC target sequencer
// Revision    : 1.0 - initial release
// ============================================================================
package plic_target_ctrl_pkg;

    localparam int unsigned ID_NO_INTERRUPT          = 0;
    localparam int unsigned PRIORITY_NEVER_INTERRUPT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

endpackage : plic_target_ctrl_pkg
`default_nettype wire

// File: rtl/plic_source_state.sv
`default_nettype none
// ============================================================================
// Module      : plic_source_state
// Description : Pending / in-service flops and gateway release for one source
// Revision    : 1.0 - initial release
// ============================================================================
module plic_source_state (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_request,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending,
    output logic o_in_service,
    output logic o_gateway_ready
);

    logic r_pending;
    logic r_in_service;
    logic r_gateway_ready;

    // A claim outranks a same-edge request, so the source cannot re-pend while
    // it is being moved into service.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pending       <= 1'b0;
            r_in_service    <= 1'b0;
            r_gateway_ready <= 1'b0;
        end else begin
            r_gateway_ready <= i_complete;
            if (i_claim) begin
                r_pending    <= 1'b0;
                r_in_service <= 1'b1;
            end else begin
                if (i_request && !r_in_service) begin
                    r_pending <= 1'b1;
                end
                if (i_complete) begin
                    r_in_service <= 1'b0;
                end
            end
        end
    end

    assign o_pending       = r_pending;
    assign o_in_service    = r_in_service;
    assign o_gateway_ready = r_gateway_ready;

endmodule : plic_source_state
`default_nettype wire

// File: rtl/plic_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : plic_target_ctrl
// Description : Per-target claim/complete sequencer with registered notification
// Revision    : 1.0 - initial release
// ============================================================================
module plic_target_ctrl
    import plic_target_ctrl_pkg::*;
#(
    parameter int N_INTERRUPT_SOURCES = 32,
    parameter int ID_WIDTH            = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_INTERRUPT_SOURCES-1:0] gateway_request_i,
    output logic [N_INTERRUPT_SOURCES-1:0] pending_o,
    output logic [N_INTERRUPT_SOURCES-1:0] in_service_o,
    input  logic [ID_WIDTH-1:0]            max_priority_i,
    input  logic [ID_WIDTH-1:0]            max_id_i,
    input  logic [ID_WIDTH-1:0]            threshold_i,
    input  logic                           claim_req_i,
    output logic                           claim_ready_o,
    output logic                           claim_valid_o,
    output logic [ID_WIDTH-1:0]            claim_id_o,
    input  logic                           complete_req_i,
    input  logic [ID_WIDTH-1:0]            complete_id_i,
    output logic                           complete_err_o,
    output logic [N_INTERRUPT_SOURCES-1:0] gateway_ready_o,
    output logic                           notification_o
);

    state_t                         r_state;
    logic                           r_claim_ready;
    logic                           r_claim_valid;
    logic [ID_WIDTH-1:0]            r_claim_id;
    logic                           r_complete_err;
    logic                           r_notify;

    logic                           w_eligible;
    logic                           w_claim_accept;
    logic [N_INTERRUPT_SOURCES-1:0] w_claim_hit;
    logic [N_INTERRUPT_SOURCES-1:0] w_cmp_hit;

    assign w_eligible = (max_priority_i > threshold_i)
                     && (max_priority_i != ID_WIDTH'(PRIORITY_NEVER_INTERRUPT))
                     && (max_id_i != ID_WIDTH'(ID_NO_INTERRUPT));
    assign w_claim_accept = claim_req_i && (r_state == ST_IDLE);

    // Completes look at the in-service bit before the edge, so completing the
    // ID that is being claimed on the same edge is rejected.
    for (genvar k = 0; k < N_INTERRUPT_SOURCES; k++) begin : g_src
        assign w_claim_hit[k] = w_claim_accept && w_eligible
                             && (max_id_i == ID_WIDTH'(k + 1));
        assign w_cmp_hit[k]   = complete_req_i && in_service_o[k]
                             && (complete_id_i == ID_WIDTH'(k + 1));

        plic_source_state u_src (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .i_request       (gateway_request_i[k]),
            .i_claim         (w_claim_hit[k]),
            .i_complete      (w_cmp_hit[k]),
            .o_pending       (pending_o[k]),
            .o_in_service    (in_service_o[k]),
            .o_gateway_ready (gateway_ready_o[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_claim_ready  <= 1'b1;
            r_claim_valid  <= 1'b0;
            r_claim_id     <= '0;
            r_complete_err <= 1'b0;
            r_notify       <= 1'b0;
        end else begin
            r_claim_valid  <= 1'b0;
            r_complete_err <= complete_req_i && !(|w_cmp_hit);
            case (r_state)
                ST_IDLE: begin
                    if (w_claim_accept) begin
                        r_claim_id    <= w_eligible ? max_id_i : ID_WIDTH'(ID_NO_INTERRUPT);
                        r_claim_valid <= 1'b1;
                        r_claim_ready <= 1'b0;
                        r_notify      <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_notify <= w_eligible;
                    end
                end
                ST_RESP: begin
                    r_notify <= 1'b0;
                    r_state  <= ST_SETTLE;
                end
                // Extra cycle lets the chain drop the just-claimed source.
                ST_SETTLE: begin
                    r_notify      <= 1'b0;
                    r_claim_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_notify      <= 1'b0;
                    r_claim_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign claim_ready_o  = r_claim_ready;
    assign claim_valid_o  = r_claim_valid;
    assign claim_id_o     = r_claim_id;
    assign complete_err_o = r_complete_err;
    assign notification_o = r_notify;

endmodule : plic_target_ctrl
`default_nettype wire
